// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encoding, controller states and HI/LO width for the mul/div block
package muldiv_pkg;
  localparam int HL_W = 32;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_ARM, S_DIV_RUN, S_DIV_CAP} md_state_t;
endpackage

// File: rtl/muldiv_mul_pipe.sv
// muldiv_mul_pipe: LAT-stage signed/unsigned 33x33 multiplier keeping the low 64 product bits
//   i_clk/i_rst  clock, sync active-high reset (clears valid bits only)
//   i_valid      operands present; i_sign 1 = signed
//   i_a/i_b      32-bit operands
//   o_valid/o_p  product valid and product, LAT cycles after i_valid
module muldiv_mul_pipe import muldiv_pkg::*; #(
  parameter int LAT = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic                i_sign,
  input  logic [HL_W-1:0]     i_a,
  input  logic [HL_W-1:0]     i_b,
  output logic                o_valid,
  output logic [2*HL_W-1:0]   o_p
);
  logic signed [2*HL_W-1:0] w_a, w_b;
  logic [2*HL_W-1:0] r_p [LAT];
  logic [LAT-1:0] r_v;
  // extending to 64 bits and keeping the low 64 product bits equals the 33x33 result
  assign w_a = {{HL_W{i_sign & i_a[HL_W-1]}}, i_a};
  assign w_b = {{HL_W{i_sign & i_b[HL_W-1]}}, i_b};
  always_ff @(posedge i_clk) begin
    r_p[0] <= w_a * w_b;
    for (int i = 1; i < LAT; i++) r_p[i] <= r_p[i-1];
    r_v <= i_rst ? '0 : LAT'({r_v, i_valid});
  end
  assign o_valid = r_v[LAT-1];
  assign o_p = r_p[LAT-1];
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO issue and result stage around an external iterative divider
//   i_clk/i_reset               clock, sync active-high reset
//   i_op_valid/i_op/i_op_a/i_op_b/i_flush  op from EX; o_stall holds EX
//   o_rd_data/o_rd_valid        MFHI/MFLO result, same cycle as accept
//   o_div_start/o_div_sign/o_div_a/o_div_b, i_div_busy, i_div_c  divider handshake
//   o_hi/o_lo                   architectural HI/LO
//   MUL_DIV_ZERO_FASTPATH_EN    when defined, divide-by-zero skips the divider
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int MUL_LAT = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_op_valid,
  input  logic [2:0]        i_op,
  input  logic [HL_W-1:0]   i_op_a,
  input  logic [HL_W-1:0]   i_op_b,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [HL_W-1:0]   o_rd_data,
  output logic              o_rd_valid,
  output logic              o_div_start,
  output logic              o_div_sign,
  output logic [HL_W-1:0]   o_div_a,
  output logic [HL_W-1:0]   o_div_b,
  input  logic              i_div_busy,
  input  logic [2*HL_W-1:0] i_div_c,
  output logic [HL_W-1:0]   o_hi,
  output logic [HL_W-1:0]   o_lo
);
  md_state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic [HL_W-1:0] r_hi, r_lo, r_div_a, r_div_b;
  logic r_div_start, r_div_sign, r_dz;
  logic w_live, w_is_div, w_is_mul, w_acc, w_mul_go, w_div_go, w_dz, w_mul_v, w_mul_done;
  logic [2*HL_W-1:0] w_mul_p;
  assign w_live = i_op_valid & ~i_flush;
  assign w_is_div = (i_op == MD_DIV) | (i_op == MD_DIVU);
  assign w_is_mul = (i_op == MD_MULT) | (i_op == MD_MULTU);
  // the divider is not reset, so a DIV must also wait for it to drain
  assign o_stall = w_live & ((r_state != S_IDLE) | (w_is_div & i_div_busy));
  assign w_acc = w_live & ~o_stall;
  assign w_mul_go = w_acc & w_is_mul;
  assign w_div_go = w_acc & w_is_div;
`ifdef MUL_DIV_ZERO_FASTPATH_EN
  assign w_dz = i_op_b == '0;
`else
  assign w_dz = 1'b0;
`endif
  assign o_rd_valid = w_acc & ((i_op == MD_MFHI) | (i_op == MD_MFLO));
  assign o_rd_data = (i_op == MD_MFHI) ? r_hi : r_lo;
  assign w_mul_done = (r_state == S_MUL) & (r_cnt == 3'd1) & w_mul_v;
  muldiv_mul_pipe #(.LAT(MUL_LAT)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_valid (w_mul_go),
    .i_sign  (i_op == MD_MULT),
    .i_a     (i_op_a),
    .i_b     (i_op_b),
    .o_valid (w_mul_v),
    .o_p     (w_mul_p)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_mul_go ? S_MUL : w_div_go ? (w_dz ? S_DIV_CAP : S_DIV_ARM) : S_IDLE;
      S_MUL:     w_next = (r_cnt == 3'd1) ? S_IDLE : S_MUL;
      S_DIV_ARM: w_next = S_DIV_RUN;
      S_DIV_RUN: w_next = i_div_busy ? S_DIV_RUN : S_DIV_CAP;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) r_state <= i_reset ? S_IDLE : w_next;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
      r_cnt <= '0;
      r_div_start <= 1'b0;
      r_div_sign <= 1'b0;
      r_div_a <= '0;
      r_div_b <= '0;
      r_dz <= 1'b0;
    end else begin
      r_div_start <= w_div_go & ~w_dz;
      if (w_mul_go) r_cnt <= 3'(MUL_LAT);
      else if (r_state == S_MUL) r_cnt <= r_cnt - 3'd1;
      if (w_div_go) begin
        r_div_a <= i_op_a;
        r_div_b <= i_op_b;
        r_div_sign <= i_op == MD_DIV;
        r_dz <= w_dz;
      end
      if (w_acc & (i_op == MD_MTHI)) r_hi <= i_op_a;
      if (w_acc & (i_op == MD_MTLO)) r_lo <= i_op_a;
      if (w_mul_done) {r_hi, r_lo} <= w_mul_p;
      if (r_state == S_DIV_CAP) {r_hi, r_lo} <= r_dz ? {r_div_a, {HL_W{1'b1}}} : i_div_c;
    end
  end
  assign o_div_start = r_div_start;
  assign o_div_sign = r_div_sign;
  assign o_div_a = r_div_a;
  assign o_div_b = r_div_b;
  assign o_hi = r_hi;
  assign o_lo = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench with a transaction-level HI/LO model and a stand-in divider
module tb_muldiv_ctrl;
  import muldiv_pkg::*;
  localparam int MUL_LAT = 3;
  localparam int DIV_N = 4;
`ifdef MUL_DIV_ZERO_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic o_stall, o_rd_valid, o_div_start, o_div_sign, div_busy;
  logic [31:0] o_rd_data, o_div_a, o_div_b, o_hi, o_lo;
  logic [63:0] div_c = '0;
  int n_err = 0, n_chk = 0, n_starts = 0;
  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .i_clk(clk), .i_reset(rst), .i_op_valid(op_valid), .i_op(op), .i_op_a(a), .i_op_b(b),
    .i_flush(flush), .o_stall(o_stall), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_div_start(o_div_start), .o_div_sign(o_div_sign), .o_div_a(o_div_a), .o_div_b(o_div_b),
    .i_div_busy(div_busy), .i_div_c(div_c), .o_hi(o_hi), .o_lo(o_lo)
  );

  function automatic logic [63:0] div_ref(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    longint unsigned ux, uy;
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return {32'(sx % sy), 32'(sx / sy)};
    end
    ux = x;
    uy = y;
    return {32'(ux % uy), 32'(ux / uy)};
  endfunction

  function automatic logic [63:0] mul_ref(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    longint unsigned ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    return s ? 64'(sx * sy) : 64'(ux * uy);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // stand-in divider: busy DIV_N cycles after start, result register loads on the edge after busy falls
  logic d_busy = 1'b0, d_ld = 1'b0, force_busy = 1'b0;
  int d_cnt = 0;
  logic [63:0] d_res = '0;
  assign div_busy = d_busy | force_busy;
  always @(posedge clk) begin
    if (o_div_start) begin
      d_cnt <= DIV_N;
      d_busy <= 1'b1;
      d_res <= div_ref(o_div_a, o_div_b, o_div_sign);
    end else if (d_cnt > 1) d_cnt <= d_cnt - 1;
    else if (d_cnt == 1) begin
      d_cnt <= 0;
      d_busy <= 1'b0;
      d_ld <= 1'b1;
    end else if (d_ld) begin
      div_c <= d_res;
      d_ld <= 1'b0;
    end
  end

  // model: an accepted MULT/DIV schedules one HI/LO write at a fixed edge; EX stalls until then
  logic [31:0] mhi = '0, mlo = '0, m_da = '0, m_db = '0;
  logic m_busy = 1'b0, m_start = 1'b0, m_ds = 1'b0;
  logic [63:0] p_val = '0;
  int cyc = 0, p_cyc = 0;
  logic m_isdiv, m_stall, m_acc, m_rdv;
  assign m_isdiv = (op == MD_DIV) || (op == MD_DIVU);
  assign m_stall = op_valid & ~flush & (m_busy | (m_isdiv & div_busy));
  assign m_acc = op_valid & ~flush & ~m_stall;
  assign m_rdv = m_acc & ((op == MD_MFHI) || (op == MD_MFLO));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mhi <= '0;
      mlo <= '0;
      m_busy <= 1'b0;
      m_start <= 1'b0;
    end else begin
      m_start <= 1'b0;
      if (m_busy && cyc == p_cyc) begin
        {mhi, mlo} <= p_val;
        m_busy <= 1'b0;
      end
      if (m_acc) begin
        if (op == MD_MULT || op == MD_MULTU) begin
          p_val <= mul_ref(a, b, op == MD_MULT);
          p_cyc <= cyc + MUL_LAT;
          m_busy <= 1'b1;
        end else if (m_isdiv) begin
          p_val <= div_ref(a, b, op == MD_DIV);
          m_busy <= 1'b1;
          if (FAST && b == 0) p_cyc <= cyc + 1;
          else begin
            p_cyc <= cyc + DIV_N + 3;
            m_start <= 1'b1;
            m_da <= a;
            m_db <= b;
            m_ds <= op == MD_DIV;
          end
        end else if (op == MD_MTHI) mhi <= a;
        else if (op == MD_MTLO) mlo <= a;
      end
    end
  end

  always @(negedge clk) if (cyc > 0) begin
    chk("stall", o_stall, m_stall);
    chk("rd_valid", o_rd_valid, m_rdv);
    if (m_rdv) chk("rd_data", o_rd_data, (op == MD_MFHI) ? mhi : mlo);
    chk("hi", o_hi, mhi);
    chk("lo", o_lo, mlo);
    chk("div_start", o_div_start, m_start);
    if (m_start) begin
      chk("div_a", o_div_a, m_da);
      chk("div_b", o_div_b, m_db);
      chk("div_sign", o_div_sign, m_ds);
    end
    if (o_div_start === 1'b1) n_starts++;
  end

  logic [31:0] last_rd;
  logic last_rv;

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic fl, output int stalls);
    op = o;
    a = x;
    b = y;
    flush = fl;
    op_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (o_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (o_stall) begin
      n_chk++;
      n_err++;
      $display("FAIL issue_timeout: op %0d still stalled after %0d cycles", o, stalls);
    end
    last_rd = o_rd_data;
    last_rv = o_rd_valid;
    @(posedge clk);
    #2 op_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int st, n0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_hi", o_hi, 0);
    chk("rst_lo", o_lo, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_div_start", o_div_start, 0);
    chk("rst_div_a", o_div_a, 0);
    issue(MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, st);
    idle(MUL_LAT);
    chk("mult_hi", o_hi, 32'hFFFFFFFF);
    chk("mult_lo", o_lo, 32'hFFFFFFFE);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, st);
    idle(MUL_LAT);
    chk("multu_hi", o_hi, 32'h00000001);
    chk("multu_lo", o_lo, 32'hFFFFFFFE);
    n0 = n_starts;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, st);
    idle(DIV_N + 3);
    chk("div_hi", o_hi, 32'hFFFFFFFF);
    chk("div_lo", o_lo, 32'hFFFFFFFD);
    chk("div_starts", n_starts - n0, 1);
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0, st);
    issue(MD_MFLO, 32'd0, 32'd0, 1'b0, st);
    chk("mflo_stall_cycles", st, DIV_N + 3);
    chk("mflo_rd_valid", last_rv, 1);
    chk("mflo_rd_data", last_rd, 32'd14);
    chk("divu_hi", o_hi, 32'd2);
    issue(MD_MTHI, 32'h12345678, 32'd0, 1'b0, st);
    issue(MD_MFHI, 32'd0, 32'd0, 1'b0, st);
    chk("mfhi_stall_cycles", st, 0);
    chk("mfhi_rd_data", last_rd, 32'h12345678);
    issue(MD_MTLO, 32'h0000DEAD, 32'd0, 1'b1, st);
    chk("flush_stall_cycles", st, 0);
    idle(1);
    chk("flush_lo", o_lo, 32'd14);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, st);
    idle(MUL_LAT);
    chk("multu_max_hi", o_hi, 32'hFFFFFFFE);
    chk("multu_max_lo", o_lo, 32'h00000001);
    issue(MD_DIV, 32'd50, 32'd3, 1'b0, st);
    idle(3);
    force_busy = 1'b1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_run_hi", o_hi, 0);
    chk("rst_run_lo", o_lo, 0);
    n0 = n_starts;
    op = MD_DIV;
    a = 32'hFFFFFF9C;
    b = 32'd7;
    op_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("busy_gate_stall", o_stall, 1);
    @(posedge clk);
    #2 force_busy = 1'b0;
    issue(MD_DIV, 32'hFFFFFF9C, 32'd7, 1'b0, st);
    idle(DIV_N + 4);
    chk("rediv_starts", n_starts - n0, 1);
    chk("rediv_hi", o_hi, 32'hFFFFFFFE);
    chk("rediv_lo", o_lo, 32'hFFFFFFF2);
    n0 = n_starts;
    issue(MD_DIVU, 32'd5, 32'd0, 1'b0, st);
    idle(DIV_N + 4);
    chk("dz_hi", o_hi, 32'd5);
    chk("dz_lo", o_lo, 32'hFFFFFFFF);
    chk("dz_starts", n_starts - n0, FAST ? 0 : 1);
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Issue and result stage wrapped around the iterative divider core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the EX stage and owns the architectural HI/LO registers.
- Runs its own pipelined multiplier, and sequences the divider's start/busy/result protocol.
- Stalls EX whenever a new HI/LO operation would race an in-flight one.

Parameters:
- MUL_LAT, 3, multiplier pipeline depth in cycles (legal 1..4).

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- op_valid  in  1  EX presents a HI/LO op this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- op_a  in  32  rs operand (dividend/multiplicand/MT source)
- op_b  in  32  rt operand
- flush  in  1  kill the op presented this cycle
- stall  out  1  hold EX; the op is not accepted
- rd_data  out  32  MFHI/MFLO result
- rd_valid  out  1  rd_data valid this cycle
- div_start  out  1  one-cycle start pulse to the divider
- div_sign  out  1  1 = signed divide
- div_a  out  32  dividend
- div_b  out  32  divisor
- div_busy  in  1  divider busy
- div_c  in  64  divider result {rem, quot}
- hi  out  32  architectural HI (debug/commit view)
- lo  out  32  architectural LO (debug/commit view)

Behaviour:
- Reset values:
  - state = IDLE; HI = LO = 0
  - div_start = 0; div_sign = 0; div_a = div_b = 0
  - rd_valid = 0; stall = 0
- accept = op_valid & ~flush & ~stall.
- States: IDLE, MUL, DIV_ARM, DIV_RUN, DIV_CAP.
- stall (combinational) = op_valid & ~flush & (state != IDLE | (op is DIV/DIVU & div_busy)).
  - The divider has no reset and may still be busy after Reset; DIV is gated until it is idle.
- IDLE:
  - accept MULT/MULTU: operands enter the multiplier pipe, counter = MUL_LAT, go to MUL.
  - accept DIV/DIVU: register div_a/div_b/div_sign, pulse div_start for exactly one cycle, go to DIV_ARM.
  - accept MTHI/MTLO: HI/LO written with op_a at the clock edge; visible next cycle.
  - accept MFHI/MFLO: rd_data = HI/LO combinationally; rd_valid = 1 the same cycle.
  - rd_valid = 0 whenever the op is not accepted.
- MUL:
  - Counter decrements each cycle.
  - When it reaches 1: {HI,LO} <= 64-bit product, go to IDLE.
  - MULT: signed 32x32; MULTU: unsigned (33-bit sign/zero extension, low 64 bits kept).
- DIV_ARM: one cycle while the divider loads; go to DIV_RUN.
- DIV_RUN: stay while div_busy = 1; on the first cycle div_busy = 0, go to DIV_CAP.
- DIV_CAP:
  - The divider's result register updates on the edge after busy falls, so div_c is valid here.
  - HI <= div_c[63:32], LO <= div_c[31:0], go to IDLE.
- Latency:
  - MULT: MUL_LAT cycles to HI/LO update.
  - DIV: divider run time + 3 cycles.
  - MFxx issued the cycle after completion sees the new value.
- flush:
  - Suppresses the same-cycle op only.
  - An op already accepted always completes (MIPS: HI/LO writes are not cancelled).
- Reset mid-operation:
  - Drops to IDLE; the in-flight result is discarded; HI/LO = 0.
  - The multiplier pipe is not required to be cleared, but its output is never written.

Optional Feature:
- Macro: MUL_DIV_ZERO_FASTPATH_EN.
- Defined: DIV/DIVU with op_b == 0 bypasses the divider (no div_start). The block spends one cycle in DIV_CAP with HI <= op_a, LO <= 32'hFFFFFFFF, then returns to IDLE.
- Not defined: divide-by-zero goes through the divider like any other divide; HI/LO take whatever div_c returns.

Decomposition:
- Shared package (muldiv_pkg):
  - op encoding constants (MD_MULT … MD_MFLO)
  - state encoding
  - the HI/LO width constant
- One natural sub-module: muldiv_mul_pipe.
  - MUL_LAT-stage signed/unsigned 33x33 multiplier, valid in/out.
  - Owns the pipeline registers; the controller owns the counter and HI/LO.

Test Plan:
- MULT 0xFFFFFFFF x 2 -> after MUL_LAT cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7 / 2 -> single div_start pulse, div_sign=1; after completion LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- MFLO issued the cycle after DIV -> stall=1 until DIV_CAP is done; next cycle rd_valid=1, rd_data=quotient.
- MTHI 0x12345678 then MFHI back-to-back -> no stall; rd_data=0x12345678 in the second cycle.
- Reset asserted in DIV_RUN with div_busy held high -> HI=LO=0, state IDLE. A following DIV stalls until div_busy=0, then issues exactly one div_start.
- flush with op_valid on MTLO 0xDEAD -> LO unchanged, stall=0. With MUL_DIV_ZERO_FASTPATH_EN: DIVU 5/0 -> no div_start; HI=5, LO=0xFFFFFFFF.
